// File: rtl/calc_run_ctrl.sv
// Run sequencer and data-memory port arbiter for one calculator operation.
// Optional CALC_RESULT_LATCH_EN: capture the completing DONE_ADDR write data into result.
module calc_run_ctrl #(
  parameter int unsigned RUN_CYCLES = 200,
  parameter logic [31:0] DONE_ADDR  = 32'd460,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        host_go,
  input  logic        host_clear,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rd_valid,
  output logic [31:0] host_rd_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rd_valid,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cpu_run;
  logic               r_host_pend;
  logic               r_cpu_pend;
  logic [31:0]        r_host_data;
  logic               w_in_run;
  logic               w_cpu_gnt;
  logic               w_host_gnt;
  logic               w_done_wr;
  logic               w_last;
  logic               w_start;

  assign w_in_run   = (r_state == S_RUN);
  assign w_cpu_gnt  = w_in_run & cpu_req;
  assign w_host_gnt = host_req & ~w_cpu_gnt;
  assign w_done_wr  = w_cpu_gnt & cpu_we & (cpu_addr == DONE_ADDR);
  assign w_last     = (r_cnt == CNT_W'(RUN_CYCLES - 1));
  assign w_start    = host_go & ~host_clear & ~w_in_run;

  always_comb begin
    w_next = r_state;
    if (host_clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (host_go) w_next = S_RUN;
        S_RUN: begin
          if (w_done_wr)   w_next = S_DONE;
          else if (w_last) w_next = S_TIMEOUT;
        end
        S_DONE,
        S_TIMEOUT: if (host_go) w_next = S_RUN;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cpu_run <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cpu_run <= (w_next == S_RUN);
      if (w_start)       r_cnt <= '0;
      else if (w_in_run) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Read data returns the cycle after the grant; a clear in that cycle drops it.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_host_pend <= 1'b0;
      r_cpu_pend  <= 1'b0;
      r_host_data <= '0;
    end else begin
      r_host_pend <= w_host_gnt & ~host_we;
      r_cpu_pend  <= w_cpu_gnt & ~cpu_we;
      if (host_rd_valid) r_host_data <= mem_rdata;
    end
  end

  assign host_gnt      = w_host_gnt;
  assign cpu_gnt       = w_cpu_gnt;
  assign host_rd_valid = r_host_pend & ~host_clear;
  assign host_rd_data  = host_rd_valid ? mem_rdata : r_host_data;
  assign cpu_rd_valid  = r_cpu_pend & ~host_clear;
  assign cpu_rdata     = mem_rdata;

  assign mem_en    = w_host_gnt | w_cpu_gnt;
  assign mem_we    = (w_cpu_gnt & cpu_we) | (w_host_gnt & host_we);
  assign mem_addr  = w_cpu_gnt ? cpu_addr  : host_addr;
  assign mem_wdata = w_cpu_gnt ? cpu_wdata : host_wdata;

  assign cpu_run = r_cpu_run;
  assign busy    = w_in_run;
  assign done    = (r_state == S_DONE);
  assign timeout = (r_state == S_TIMEOUT);

`ifdef CALC_RESULT_LATCH_EN
  logic [31:0] r_result;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
    end else if (host_clear || w_start) begin
      r_result <= '0;
    end else if (w_done_wr) begin
      r_result <= cpu_wdata;
    end
  end

  assign result = r_result;
`else
  assign result = '0;
`endif

endmodule

// File: tb/tb_calc_run_ctrl.sv
// Directed bench for calc_run_ctrl: arbitration vector table plus run/done/timeout/reset sequences.
module tb_calc_run_ctrl;

  logic        hz100 = 1'b0;
  logic        reset;
  logic        host_go, host_clear, host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic        host_gnt, host_rd_valid;
  logic [31:0] host_rd_data;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rd_valid;
  logic [31:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_run, busy, done, timeout;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CALC_RESULT_LATCH_EN
  localparam logic [31:0] RES_EN = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] RES_EN = 32'h0;
`endif

  calc_run_ctrl #(
    .RUN_CYCLES (200),
    .DONE_ADDR  (32'd460),
    .CNT_W      (16)
  ) dut (
    .hz100         (hz100),
    .reset         (reset),
    .host_go       (host_go),
    .host_clear    (host_clear),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_gnt       (cpu_gnt),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_rdata     (cpu_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .cpu_run       (cpu_run),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .result        (result)
  );

  always #5 hz100 = ~hz100;

  // Synchronous memory with one-cycle read latency.
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge hz100) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    host_go = 0; host_clear = 0; host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic tick();
    @(posedge hz100); #1;
  endtask

  // go for one cycle, hold go for the first 5 RUN cycles, count RUN cycles until it ends.
  task automatic run_to_timeout(input string tag);
    int n;
    n = 0;
    tick(); host_go = 1;
    @(negedge hz100);
    chk({tag, "_busy_go_cycle"}, 32'(busy), 32'd0);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (k == 5) host_go = 0;
      @(negedge hz100);
      if (!busy) break;
      if (k == 0) chk({tag, "_cpu_run_first"}, 32'(cpu_run), 32'd1);
      n++;
    end
    host_go = 0;
    chk({tag, "_run_cycles"}, 32'(n), 32'd200);
    chk({tag, "_timeout"}, 32'(timeout), 32'd1);
    chk({tag, "_done_at_to"}, 32'(done), 32'd0);
    chk({tag, "_cpu_run_at_to"}, 32'(cpu_run), 32'd0);
  endtask

  typedef struct {
    logic [31:0] go, clr, hreq, hwe, haddr, hwd;
    logic [31:0] creq, cwe, caddr, cwd;
    logic [31:0] e_hgnt, e_cgnt, e_men, e_mwe, e_maddr, e_mwd;
    logic [31:0] e_busy, e_run, e_hrv, e_hrd, e_crv, e_crd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0,0, 1,1,220,7,   0,0,0,0,        1,0,1,1,220,7,      0,0,0,0,0,0};
    vecs[1] = '{0,0, 1,1,300,3,   0,0,0,0,        1,0,1,1,300,3,      0,0,0,0,0,0};
    vecs[2] = '{0,0, 1,1,260,5,   0,0,0,0,        1,0,1,1,260,5,      0,0,0,0,0,0};
    vecs[3] = '{0,0, 1,0,220,0,   1,0,300,0,      1,0,1,0,220,0,      0,0,0,0,0,0};
    vecs[4] = '{1,0, 0,0,0,0,     0,0,0,0,        0,0,0,0,0,0,        0,0,1,7,0,0};
    vecs[5] = '{0,0, 1,0,260,0,   1,0,300,0,      0,1,1,0,300,0,      1,1,0,7,0,0};
    vecs[6] = '{0,0, 1,0,260,0,   0,0,0,0,        1,0,1,0,260,0,      1,1,0,7,1,3};
    vecs[7] = '{0,0, 1,1,220,9,   1,1,100,'hAA,   0,1,1,1,100,'hAA,   1,1,1,5,0,0};
    vecs[8] = '{0,0, 1,0,100,0,   0,0,0,0,        1,0,1,0,100,0,      1,1,0,5,0,0};
    vecs[9] = '{0,0, 0,0,0,0,     0,0,0,0,        0,0,0,0,0,0,        1,1,1,'hAA,0,0};

    reset = 0;
    idle_inputs();
    @(negedge hz100);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_hrv", 32'(host_rd_valid), 0);
    chk("rst_crv", 32'(cpu_rd_valid), 0);
    chk("rst_hrd", host_rd_data, 0);
    chk("rst_result", result, 0);
    tick(); reset = 1;

    for (int i = 0; i < 10; i++) begin
      tick();
      host_go = vecs[i].go[0]; host_clear = vecs[i].clr[0];
      host_req = vecs[i].hreq[0]; host_we = vecs[i].hwe[0];
      host_addr = vecs[i].haddr; host_wdata = vecs[i].hwd;
      cpu_req = vecs[i].creq[0]; cpu_we = vecs[i].cwe[0];
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      @(negedge hz100);
      chk($sformatf("v%0d_host_gnt", i), 32'(host_gnt), vecs[i].e_hgnt);
      chk($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), vecs[i].e_cgnt);
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), vecs[i].e_men);
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), vecs[i].e_mwe);
      if (vecs[i].e_men[0]) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwd);
      end
      chk($sformatf("v%0d_busy", i), 32'(busy), vecs[i].e_busy);
      chk($sformatf("v%0d_cpu_run", i), 32'(cpu_run), vecs[i].e_run);
      chk($sformatf("v%0d_host_rd_valid", i), 32'(host_rd_valid), vecs[i].e_hrv);
      chk($sformatf("v%0d_host_rd_data", i), host_rd_data, vecs[i].e_hrd);
      chk($sformatf("v%0d_cpu_rd_valid", i), 32'(cpu_rd_valid), vecs[i].e_crv);
      if (vecs[i].e_crv[0]) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
    end
    idle_inputs();

    // CPU completes by storing to DONE_ADDR while the host waits on the same address.
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 460; cpu_wdata = 32'h23;
    host_req = 1; host_we = 0; host_addr = 460;
    @(negedge hz100);
    chk("done_wr_cpu_gnt", 32'(cpu_gnt), 1);
    chk("done_wr_host_gnt", 32'(host_gnt), 0);
    chk("done_wr_mem_addr", mem_addr, 460);
    chk("done_wr_mem_wdata", mem_wdata, 32'h23);
    tick(); cpu_req = 0; cpu_we = 0;
    @(negedge hz100);
    chk("done_flag", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_timeout", 32'(timeout), 0);
    chk("done_cpu_run", 32'(cpu_run), 0);
    chk("done_result", result, 32'h23 & RES_EN);
    chk("done_host_gnt", 32'(host_gnt), 1);
    tick(); host_req = 0;
    @(negedge hz100);
    chk("done_rd_valid", 32'(host_rd_valid), 1);
    chk("done_rd_data", host_rd_data, 32'h23);

    // Clear in the cycle after a granted host read drops the returning data.
    tick(); host_req = 1; host_we = 0; host_addr = 220;
    @(negedge hz100);
    chk("clr_rd_gnt", 32'(host_gnt), 1);
    tick(); host_req = 0; host_clear = 1;
    @(negedge hz100);
    chk("clr_rd_valid", 32'(host_rd_valid), 0);
    chk("clr_rd_data", host_rd_data, 32'h23);
    tick(); host_clear = 0;
    @(negedge hz100);
    chk("clr_rd_valid_after", 32'(host_rd_valid), 0);
    chk("clr_rd_data_after", host_rd_data, 32'h23);
    chk("clr_done", 32'(done), 0);
    chk("clr_result", result, 0);
    chk("clr_busy", 32'(busy), 0);

    run_to_timeout("to");

    // Done write landing on the final budget cycle wins over timeout.
    tick(); host_go = 1;
    @(negedge hz100);
    tick(); host_go = 0;
    @(negedge hz100);
    for (int k = 1; k < 199; k++) tick();
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 460; cpu_wdata = 32'h55;
    @(negedge hz100);
    chk("last_cpu_gnt", 32'(cpu_gnt), 1);
    chk("last_busy", 32'(busy), 1);
    tick(); idle_inputs();
    @(negedge hz100);
    chk("last_done", 32'(done), 1);
    chk("last_timeout", 32'(timeout), 0);
    chk("last_result", result, 32'h55 & RES_EN);
    tick(); host_go = 1; host_clear = 1;
    @(negedge hz100);
    chk("goclr_done_before", 32'(done), 1);
    chk("goclr_cpu_run_before", 32'(cpu_run), 0);
    tick(); idle_inputs();
    @(negedge hz100);
    chk("goclr_busy", 32'(busy), 0);
    chk("goclr_done", 32'(done), 0);
    chk("goclr_timeout", 32'(timeout), 0);
    chk("goclr_cpu_run", 32'(cpu_run), 0);
    chk("goclr_result", result, 0);
    tick();
    @(negedge hz100);
    chk("goclr_cpu_run_later", 32'(cpu_run), 0);
    chk("goclr_busy_later", 32'(busy), 0);

    // Asynchronous reset in the RUN cycle with counter=50.
    tick(); host_go = 1;
    @(negedge hz100);
    tick(); host_go = 0;
    for (int k = 1; k <= 50; k++) tick();
    #2 reset = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cpu_run", 32'(cpu_run), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_timeout", 32'(timeout), 0);
    chk("arst_hrv", 32'(host_rd_valid), 0);
    chk("arst_crv", 32'(cpu_rd_valid), 0);
    chk("arst_hrd", host_rd_data, 0);
    chk("arst_result", result, 0);
    tick(); reset = 1;
    @(negedge hz100);
    chk("arst_busy_release", 32'(busy), 0);
    run_to_timeout("arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_run_ctrl.md
Name: calc_run_ctrl

Overview:
- Sequences the CPU for one calculator operation and shares the single data-memory port between the keypad front end (host) and the CPU.
- Host writes operands and the opcode, pulses go, and the CPU runs until it stores to DONE_ADDR or the cycle budget expires.
- Host then reads results back through the same port.
- Sits between the keypad/display front end, the CPU data interface and the data memory.

Parameters:
RUN_CYCLES, 200, maximum RUN-state cycles before timeout (≥2)
DONE_ADDR, 32'd460, a granted CPU write to this address marks completion
CNT_W, 16, width of the run-cycle counter; must hold RUN_CYCLES

Ports:
hz100  in  1  clock, all state on its rising edge
reset  in  1  asynchronous active-low reset
host_go  in  1  level; start a run
host_clear  in  1  level; abort and return to IDLE
host_req  in  1  host memory request
host_we  in  1  1 = write, 0 = read
host_addr  in  32  host address
host_wdata  in  32  host write data
host_gnt  out  1  combinational; host request accepted this cycle
host_rd_valid  out  1  one-cycle pulse; host_rd_data updated
host_rd_data  out  32  last host read data, held
cpu_req  in  1  CPU memory request
cpu_we  in  1  CPU write
cpu_addr  in  32  CPU address
cpu_wdata  in  32  CPU write data
cpu_gnt  out  1  combinational; CPU request accepted
cpu_rd_valid  out  1  one-cycle pulse for a granted CPU read
cpu_rdata  out  32  equals mem_rdata
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  32  muxed address
mem_wdata  out  32  muxed write data
mem_rdata  in  32  synchronous memory; valid the cycle after mem_en with mem_we=0
cpu_run  out  1  CPU clock-enable, registered
busy  out  1  high in RUN
done  out  1  sticky; run ended by DONE_ADDR write
timeout  out  1  sticky; run ended by budget
result  out  32  see Optional Feature

Behaviour:
- Reset values: state IDLE; cpu_run, busy, done, timeout, host_rd_valid, cpu_rd_valid = 0; host_rd_data, result, run counter = 0.
- States:
  - IDLE: go → RUN.
  - RUN: granted CPU write with cpu_addr==DONE_ADDR → DONE; counter==RUN_CYCLES-1 → TIMEOUT.
  - DONE / TIMEOUT: go → RUN.
  - Any state: clear → IDLE.
- Priority: clear beats go, and both beat every other transition in the same cycle. The done write beats timeout in the same cycle: done=1, timeout=0.
- Entering RUN: counter←0, done←0, timeout←0; cpu_run=1 from the next cycle through the last RUN cycle.
- Counter: increments each RUN cycle. cpu_run falls the cycle after leaving RUN.
- go held high in RUN: ignored.
- Arbitration:
  - Outside RUN: host_gnt = host_req; cpu_gnt = 0.
  - In RUN: cpu_gnt = cpu_req; host_gnt = host_req & ~cpu_req. CPU has priority and the host uses idle cycles.
  - At most one grant per cycle. mem_* carries the granted requester's signals; mem_en = host_gnt | cpu_gnt.
- Read latency: one cycle.
  - Granted host read → next cycle host_rd_valid=1 and host_rd_data←mem_rdata; data held until the next host read.
  - Granted CPU read → next cycle cpu_rd_valid=1.
- Writes complete in the grant cycle; no acknowledge beyond gnt.
- clear asserted the cycle after a granted read: the rd_valid pulse is suppressed and data is not updated.
- Ungranted requesters must hold their request; the block stores nothing for them.

Optional Feature:
- Macro CALC_RESULT_LATCH_EN.
- Defined: the write data of the completing DONE_ADDR write is latched into result in the same edge that sets done. result holds until the next go or clear, either of which zeroes it.
- Undefined: result is tied to 0 and no register is built.

Test Plan:
- Reset mid-RUN (reset low on counter=50) → all outputs 0 and state IDLE immediately; after release, go starts a fresh run with counter 0.
- Host writes 0x7→220, 0x3→300, 0x5→260 in IDLE → host_gnt=1 each cycle; mem_addr/mem_wdata match; go → cpu_run=1 the next cycle.
- In RUN, CPU stores 0x23 to 460 → done=1 and busy=0 the next cycle, timeout=0; with CALC_RESULT_LATCH_EN, result=0x23. Host read of 460 → host_rd_valid one cycle later with data 0x23.
- RUN with cpu_req low for 200 cycles → timeout=1 after exactly RUN_CYCLES cycles; cpu_run falls the next cycle; done=0.
- Contention in RUN: cpu_req and host_req both high → cpu_gnt=1, host_gnt=0; cpu_req drops → host_gnt=1 that cycle.
- Done write on counter=RUN_CYCLES-1 → done=1, timeout=0. go and clear together in DONE → IDLE, flags cleared, cpu_run stays 0.
